// File: rtl/iq_tone_gen.sv
// iq_tone_gen: quadrature test-tone source (phase accumulator + 16-entry sine LUT) feeding offset-binary I/Q codes.
// Latency: first beat is valid the cycle after start; all outputs come straight from registers.
// Backpressure: valid/ready; while valid && !ready the codes and phase hold. Build option IQ_TONE_IMPAIR_EN enables gain/phase imbalance.
module iq_tone_gen #(
  parameter int PHASE_W = 8,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               en,
  input  logic               start,
  input  logic [LEN_W-1:0]   burst_len,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [2:0]         gain_adj,
  input  logic [1:0]         phase_skew,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [3:0]         Ix_out,
  output logic [3:0]         Qx_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Mid-scale code: what the sink sees while no tone is running.
  localparam logic [3:0] CODE_MID = 4'd8;

  state_t             state_q;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [LEN_W-1:0]   count_q;
  logic               cont_q;
  logic               out_valid_q;
  logic [3:0]         ix_q, qx_q;
  logic               done_q;

  logic               accept;
  logic               start_ok;
  logic [3:0]         kidx_d;
  logic signed [2:0]  gain_s;
  logic [1:0]         skew_s;
  logic signed [3:0]  i_base, q_base, i_sat;
  logic signed [7:0]  i_ext, g_ext, i_prod, i_shift;
  logic [3:0]         ix_d, qx_d;

  assign accept   = out_valid_q && out_ready;
  assign start_ok = (state_q == S_IDLE) && start && en;

  // S[k] = round(7*sin(2*pi*k/16)), two's complement
  function automatic logic signed [3:0] sine_lut(input logic [3:0] k);
    logic signed [3:0] s;
    case (k)
      4'd0:    s = 4'h0;
      4'd1:    s = 4'h3;
      4'd2:    s = 4'h5;
      4'd3:    s = 4'h6;
      4'd4:    s = 4'h7;
      4'd5:    s = 4'h6;
      4'd6:    s = 4'h5;
      4'd7:    s = 4'h3;
      4'd8:    s = 4'h0;
      4'd9:    s = 4'hD;   // -3
      4'd10:   s = 4'hB;   // -5
      4'd11:   s = 4'hA;   // -6
      4'd12:   s = 4'h9;   // -7
      4'd13:   s = 4'hA;   // -6
      4'd14:   s = 4'hB;   // -5
      default: s = 4'hD;   // k=15: -3
    endcase
    return s;
  endfunction

  // Clamp a scaled sample back into the signed 4-bit range [-8, 7]
  function automatic logic signed [3:0] sat4(input logic signed [7:0] v);
    logic signed [3:0] r;
    if (v > 8'sd7)       r = 4'b0111;
    else if (v < -8'sd8) r = 4'b1000;
    else                 r = v[3:0];
    return r;
  endfunction

`ifdef IQ_TONE_IMPAIR_EN
  assign gain_s = gain_adj;
  assign skew_s = phase_skew;
`else
  // Ideal quadrature: trim inputs exist on the port list but have no effect.
  logic unused_impair;
  assign unused_impair = ^{gain_adj, phase_skew};
  assign gain_s = 3'sd0;
  assign skew_s = 2'd0;
`endif

  // Next phase: cleared on burst start, advanced only when a beat is taken
  always_comb begin
    phase_d = phase_q;
    if (start_ok)
      phase_d = '0;
    else if ((state_q == S_RUN) && accept)
      phase_d = phase_q + freq_word;
  end

  // Tone codes for the next phase, so the output registers load a fresh beat in one step
  always_comb begin
    kidx_d  = phase_d[PHASE_W-1 -: 4];
    i_base  = sine_lut(kidx_d + 4'd4);
    q_base  = sine_lut(kidx_d + {{2{skew_s[1]}}, skew_s});
    i_ext   = {{4{i_base[3]}}, i_base};
    g_ext   = 8'sd8 + {{5{gain_s[2]}}, gain_s};
    i_prod  = i_ext * g_ext;           // |7*11| fits in 8 signed bits
    i_shift = i_prod >>> 3;            // arithmetic shift = floor divide by 8
    i_sat   = sat4(i_shift);
    ix_d    = {~i_sat[3], i_sat[2:0]};
    qx_d    = {~q_base[3], q_base[2:0]};
  end

  // Burst FSM with registered handshake, code and status outputs
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      count_q     <= '0;
      cont_q      <= 1'b0;
      out_valid_q <= 1'b0;
      ix_q        <= CODE_MID;
      qx_q        <= CODE_MID;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q     <= S_RUN;
            phase_q     <= phase_d;
            count_q     <= burst_len;
            cont_q      <= (burst_len == '0);
            out_valid_q <= 1'b1;
            ix_q        <= ix_d;
            qx_q        <= qx_d;
          end
        end
        S_RUN: begin
          if (!en) begin
            // Abort: drop valid next cycle, no completion pulse
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            ix_q        <= CODE_MID;
            qx_q        <= CODE_MID;
          end else if (accept) begin
            phase_q <= phase_d;
            if (!cont_q && (count_q == LEN_W'(1))) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b0;
              ix_q        <= CODE_MID;
              qx_q        <= CODE_MID;
              done_q      <= 1'b1;
            end else begin
              if (!cont_q)
                count_q <= count_q - LEN_W'(1);
              ix_q <= ix_d;
              qx_q <= qx_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign Ix_out    = ix_q;
  assign Qx_out    = qx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
